// File: rtl/if_fetch_if.sv
// -----------------------------------------------------------------------------
// if_fetch_if
//   Instruction-memory bus between the fetch stage and a combinational
//   instruction memory.
//
//   Signals:
//     im_address  12  byte address presented by the fetch stage (pc[11:0])
//     im_now      32  instruction word returned combinationally by the memory
//
//   Modports:
//     master  fetch stage  (drives im_address, reads im_now)
//     slave   memory       (reads im_address, drives im_now)
// -----------------------------------------------------------------------------
interface if_fetch_if;
  logic [11:0] im_address;
  logic [31:0] im_now;

  modport master (output im_address, input  im_now);
  modport slave  (input  im_address, output im_now);
endinterface : if_fetch_if

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage of the MIPS pipeline. Holds the program counter,
//   presents pc[11:0] to the combinational instruction memory and registers
//   the returned word plus PC+4 into the IF/ID pipeline register. Handles
//   decode stalls, branch/jump redirects and a syscall halt/resume FSM.
//
//   Parameters:
//     RESET_PC           PC loaded on reset (bits [1:0] must be 0)
//
//   Build option:
//     FETCH_CNT_EN       when defined, o_fetch_count counts every instruction
//                        latched valid into IF/ID; otherwise it is tied to 0
//                        and no counter is built.
//
//   Ports:
//     clk                rising-edge clock
//     rst                synchronous active-high reset
//     i_stall            hold PC and IF/ID (load-use hazard)
//     i_redirect_valid   taken branch/jump this cycle
//     i_redirect_target  new PC (bits [1:0] forced to 0)
//     i_halt             syscall halt request
//     i_resume           leave HALTED
//     im_bus             instruction-memory bus (master side)
//     o_pc               current fetch PC
//     o_ifid_instr       registered instruction
//     o_ifid_pc4         registered PC+4 of that instruction
//     o_ifid_valid       IF/ID holds a real instruction (0 = bubble)
//     o_halted           FSM is in HALTED
//     o_fetch_count      instructions latched valid into IF/ID
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_target,
  input  logic               i_halt,
  input  logic               i_resume,
  if_fetch_if.master         im_bus,
  output logic [31:0]        o_pc,
  output logic [31:0]        o_ifid_instr,
  output logic [31:0]        o_ifid_pc4,
  output logic               o_ifid_valid,
  output logic               o_halted,
  output logic [31:0]        o_fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic        r_halted;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign w_pc_plus4    = r_pc + 32'd4;
  // Masking keeps every target bit in the expression while forcing word alignment.
  assign w_redirect_pc = i_redirect_target & ~32'h0000_0003;

  // The memory address is a plain copy of the PC so it tracks it in every state.
  assign im_bus.im_address = r_pc[11:0];

  // ---------------------------------------------------------------------------
  // Fetch FSM and IF/ID register.
  // RUN priority: halt > redirect > stall > normal fetch. In HALTED everything
  // holds and only resume is honoured.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_halt) begin
            r_state      <= ST_HALTED;
            r_halted     <= 1'b1;
            r_ifid_valid <= 1'b0;
          end else if (i_redirect_valid) begin
            // Wrong-path word currently at im_now is squashed; takes effect
            // even during a stall so the branch is never lost.
            r_pc         <= w_redirect_pc;
            r_ifid_valid <= 1'b0;
          end else if (!i_stall) begin
            r_ifid_instr <= im_bus.im_now;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc_plus4;
          end
        end
        ST_HALTED: begin
          // Fetch restarts from the held PC on the edge after resume.
          if (i_resume) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional fetch counter.
  // ---------------------------------------------------------------------------
`ifdef FETCH_CNT_EN
  logic        w_latch;
  logic [31:0] r_fetch_count;

  // Same condition as the normal-fetch branch of the FSM.
  assign w_latch = (r_state == ST_RUN) && !i_halt && !i_redirect_valid && !i_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'h0;
    end else if (w_latch) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`else
  assign o_fetch_count = 32'h0;
`endif

  assign o_pc         = r_pc;
  assign o_ifid_instr = r_ifid_instr;
  assign o_ifid_pc4   = r_ifid_pc4;
  assign o_ifid_valid = r_ifid_valid;
  assign o_halted     = r_halted;

endmodule : if_fetch

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the MIPS CPU. Holds the program counter, drives the byte address into the combinational instruction memory, and registers the returned word plus PC+4 into the IF/ID pipeline register. Handles decode-stage stalls, branch/jump redirects, and a syscall halt/resume state machine. Sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents (load-use hazard from decode)
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  32  new PC; bits [1:0] ignored, treated as 0
- halt  in  1  syscall-halt request from decode
- resume  in  1  leave HALTED state
- im_address  out  12  byte address to instruction memory = pc[11:0]
- im_now  in  32  instruction word returned combinationally by instruction memory
- pc  out  32  current fetch PC
- ifid_instr  out  32  registered instruction
- ifid_pc4  out  32  registered PC+4 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- halted  out  1  state is HALTED
- fetch_count  out  32  number of instructions latched valid into IF/ID

## Operation
- States: RUN, HALTED. Reset state RUN.
- Reset (rst=1 at edge): pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0, fetch_count=0. rst overrides all other inputs, including mid-halt and mid-stall.
- RUN priority, highest first: halt > redirect_valid > stall > normal.
- halt: state->HALTED, pc holds, ifid_valid<=0, ifid_instr/ifid_pc4 hold.
- redirect_valid: pc<={redirect_target[31:2],2'b00}; ifid_valid<=0 (wrong-path word squashed); applied even when stall=1.
- stall (no redirect): pc, ifid_instr, ifid_pc4, ifid_valid all hold.
- normal: ifid_instr<=im_now, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4.
- HALTED: pc and IF/ID hold, ifid_valid stays 0, halted=1; stall, redirect and halt ignored. resume=1 -> RUN next cycle; fetching restarts from held pc on the following edge.
- Arithmetic: pc+4 is modulo 2^32. im_address takes pc[11:0], so fetch wraps every 4 KiB (1024 words): pc=0x0000_0FFC -> next im_address=0x000.
- im_address always reflects the current pc, in every state.

## Timing
- im_address changes 0 cycles after the pc register updates; im_now is sampled at the same edge that advances pc.
- Fetch latency is 1 cycle: the word at pc appears on ifid_instr in the cycle after the edge.
- Redirect penalty: 1 bubble (ifid_valid=0 for one cycle); the target word is valid 2 edges after redirect_valid is sampled.
- halt sampled at edge N: halted=1 and ifid_valid=0 from N+1. resume sampled at edge M: halted=0 from M+1; the first valid instruction is latched at M+1 and visible from M+2.
- All outputs are registered except im_address (a wire copy of pc[11:0]).

## Configuration
- FETCH_CNT_EN defined: fetch_count increments by 1 on every edge that latches ifid_valid<=1, wraps modulo 2^32, and is cleared by rst.
- FETCH_CNT_EN undefined: no counter logic is built; fetch_count is tied to 0.

## Test plan
- Reset, then 4 free-running cycles with IM words 0x2008_0001.. at 0x000-0x00C -> pc 0x0,0x4,0x8,0xC,0x10; ifid_instr follows one cycle later; ifid_pc4=0x4,0x8,...; fetch_count=4 when enabled.
- stall held 3 cycles at pc=0x8 -> pc, ifid_instr and ifid_pc4=0x8 frozen for 3 cycles; on release, resumes with the word at 0x8.
- redirect_valid with target 0x0000_0043 and stall=1 -> pc=0x40; one bubble; next ifid_instr=word at 0x40 with ifid_pc4=0x44.
- halt at pc=0x20 -> halted=1, pc stays 0x20, ifid_valid=0; redirect is ignored while halted; resume -> word at 0x20 is latched 2 cycles later.
- pc=0xFFC free-run -> im_address wraps to 0x000 while pc=0x1000; ifid_pc4=0x1000.
- rst asserted while HALTED with fetch_count=7 -> pc=RESET_PC, halted=0, ifid_valid=0, fetch_count=0.
